// File: rtl/down_count_wrap_monitor_pkg.sv
// Shared defaults and the step classification used by the wrap monitor.
package down_count_wrap_monitor_pkg;

    localparam int unsigned CNT_W_DEF  = 3;
    localparam int unsigned WRAP_W_DEF = 8;

    // Relationship of the current count sample to the previous one.
    typedef enum logic [1:0] {
        CLS_HOLD    = 2'd0,
        CLS_STEP    = 2'd1,
        CLS_WRAP    = 2'd2,
        CLS_ILLEGAL = 2'd3
    } step_class_e;

endpackage

// File: rtl/down_count_wrap_monitor_count_step_classifier.sv
// Combinational classifier: compares the new count sample against the
// previous one and reports hold / decrement / wrap / illegal.
module count_step_classifier
    import down_count_wrap_monitor_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic [CNT_W-1:0] prev_in,
    input  logic             prev_valid,
    input  logic [CNT_W-1:0] cnt_in,
    output step_class_e      step_class
);

    logic [CNT_W-1:0] prev_dec;

    assign prev_dec = prev_in - CNT_W'(1);

    // Unprimed cycles report HOLD so no wrap or error can be raised.
    always_comb begin
        step_class = CLS_ILLEGAL;
        if (!prev_valid) begin
            step_class = CLS_HOLD;
        end else if (cnt_in == prev_in) begin
            step_class = CLS_HOLD;
        end else if ((prev_in != '0) && (cnt_in == prev_dec)) begin
            step_class = CLS_STEP;
        end else if ((prev_in == '0) && (cnt_in == '1)) begin
            step_class = CLS_WRAP;
        end
    end

endmodule

// File: rtl/down_count_wrap_monitor.sv
// Wrap monitor for a down counter: registered wrap tick, per-period wrap
// counting with an ack handshake, and sticky sequence/overrun errors.
module down_count_wrap_monitor
    import down_count_wrap_monitor_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic [WRAP_W-1:0] thresh,
    input  logic              ack,
    input  logic              err_clr,
    output logic              tick,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              period_done,
    output logic              overrun,
    output logic              seq_err
);

    logic [CNT_W-1:0]  prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              tick_q, tick_d;
    logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
    logic              period_done_q, period_done_d;
    logic              overrun_q, overrun_d;
    logic              seq_err_q, seq_err_d;

    logic [WRAP_W-1:0] wrap_inc;
    logic              complete;
    step_class_e       step_class;

    count_step_classifier #(
        .CNT_W (CNT_W)
    ) u_classifier (
        .prev_in    (prev_q),
        .prev_valid (prev_valid_q),
        .cnt_in     (cnt_in),
        .step_class (step_class)
    );

    assign wrap_inc = wrap_count_q + WRAP_W'(1);

    // Next-state: prev tracking, wrap counting, handshake and sticky flags.
    always_comb begin
        prev_d        = cnt_in;
        prev_valid_d  = 1'b1;
        tick_d        = 1'b0;
        wrap_count_d  = wrap_count_q;
        complete      = 1'b0;
        period_done_d = period_done_q;
        overrun_d     = overrun_q;
        seq_err_d     = seq_err_q;

        if (step_class == CLS_WRAP) begin
            tick_d = 1'b1;
            if ((thresh != '0) && (wrap_inc == thresh)) begin
                wrap_count_d = '0;
                complete     = 1'b1;
            end else begin
                wrap_count_d = wrap_inc;
            end
        end

        // Completion outranks ack so a period finishing under ack is still reported.
        if (complete) begin
            period_done_d = 1'b1;
        end else if (ack) begin
            period_done_d = 1'b0;
        end

        // Set conditions outrank err_clr on the sticky error flags.
        if (complete && period_done_q && !ack) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end

        if (step_class == CLS_ILLEGAL) begin
            seq_err_d = 1'b1;
        end else if (err_clr) begin
            seq_err_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            tick_q        <= 1'b0;
            wrap_count_q  <= '0;
            period_done_q <= 1'b0;
            overrun_q     <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            tick_q        <= tick_d;
            wrap_count_q  <= wrap_count_d;
            period_done_q <= period_done_d;
            overrun_q     <= overrun_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign tick        = tick_q;
    assign wrap_count  = wrap_count_q;
    assign period_done = period_done_q;
    assign overrun     = overrun_q;
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_down_count_wrap_monitor.sv
// Scoreboard bench for down_count_wrap_monitor: the driver queues the
// expected output set for every clock it issues; the monitor pops one
// entry per falling edge and compares it with the DUT outputs.
module tb_down_count_wrap_monitor;

    logic       clk;
    logic       rst_n;
    logic [2:0] cnt_in;
    logic [7:0] thresh;
    logic       ack;
    logic       err_clr;
    logic       tick;
    logic [7:0] wrap_count;
    logic       period_done;
    logic       overrun;
    logic       seq_err;

    typedef struct {
        logic       tick;
        logic [7:0] wc;
        logic       pd;
        logic       ov;
        logic       se;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    down_count_wrap_monitor #(
        .CNT_W  (3),
        .WRAP_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt_in      (cnt_in),
        .thresh      (thresh),
        .ack         (ack),
        .err_clr     (err_clr),
        .tick        (tick),
        .wrap_count  (wrap_count),
        .period_done (period_done),
        .overrun     (overrun),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic t, input logic [7:0] wc, input logic pd,
                            input logic ov, input logic se, input string name);
        exp_t e;
        e.tick = t; e.wc = wc; e.pd = pd; e.ov = ov; e.se = se; e.name = name;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; expectation describes outputs after that edge.
    task automatic step(input logic [2:0] c, input logic a, input logic ec,
                        input logic t, input logic [7:0] wc, input logic pd,
                        input logic ov, input logic se, input string name);
        @(negedge clk);
        cnt_in  = c;
        ack     = a;
        err_clr = ec;
        @(posedge clk);
        #1;
        push_exp(t, wc, pd, ov, se, name);
    endtask

    // Legal descent 6..0 with no tick and steady flags.
    task automatic descend(input logic [7:0] wc, input logic pd, input logic ov,
                           input logic se, input string name);
        for (int v = 6; v >= 0; v--) begin
            step(3'(v), 1'b0, 1'b0, 1'b0, wc, pd, ov, se, name);
        end
    endtask

    // Reset pulse, then the following edge primes prev with 7.
    task automatic do_reset(input logic [7:0] th);
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        cnt_in  = 3'd7;
        ack     = 1'b0;
        err_clr = 1'b0;
        thresh  = th;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: one expectation per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (tick !== e.tick || wrap_count !== e.wc || period_done !== e.pd ||
                    overrun !== e.ov || seq_err !== e.se) begin
                    errors++;
                    $display("FAIL %s: got tick=%b wc=%0d pd=%b ov=%b se=%b, exp tick=%b wc=%0d pd=%b ov=%b se=%b",
                             e.name, tick, wrap_count, period_done, overrun, seq_err,
                             e.tick, e.wc, e.pd, e.ov, e.se);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        cnt_in  = 3'd7;
        thresh  = 8'd0;
        ack     = 1'b0;
        err_clr = 1'b0;
        #1;
        push_exp(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "reset_state");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Hold at 7 after priming.
        for (int i = 0; i < 3; i++) step(3'd7, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "hold7");

        // Single descent and wrap.
        descend(8'd0, 1'b0, 1'b0, 1'b0, "descent1");
        step(3'd7, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, "wrap_tick");
        step(3'd6, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, "tick_one_cycle");

        // thresh=3: period after third wrap, then ack.
        do_reset(8'd3);
        descend(8'd0, 1'b0, 1'b0, 1'b0, "t3_d1");
        step(3'd7, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, "t3_w1");
        descend(8'd1, 1'b0, 1'b0, 1'b0, "t3_d2");
        step(3'd7, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, "t3_w2");
        descend(8'd2, 1'b0, 1'b0, 1'b0, "t3_d3");
        step(3'd7, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, "t3_period_done");
        step(3'd6, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "t3_ack_clears");

        // thresh=2, no ack over 4 wraps: overrun, then err_clr.
        do_reset(8'd2);
        descend(8'd0, 1'b0, 1'b0, 1'b0, "t2_d1");
        step(3'd7, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, "t2_w1");
        descend(8'd1, 1'b0, 1'b0, 1'b0, "t2_d2");
        step(3'd7, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, "t2_w2_done");
        descend(8'd0, 1'b1, 1'b0, 1'b0, "t2_d3");
        step(3'd7, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, "t2_w3");
        descend(8'd1, 1'b1, 1'b0, 1'b0, "t2_d4");
        step(3'd7, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, "t2_w4_overrun");
        step(3'd6, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, "t2_errclr_overrun");

        // Illegal 5->2 step, resync, legal wrap, err_clr.
        step(3'd5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, "seq_pre");
        step(3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "seq_illegal");
        step(3'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "seq_resync1");
        step(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "seq_resync0");
        step(3'd7, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1, "seq_wrap_after");
        step(3'd6, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, "seq_errclr");
        step(3'd5, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, "seq_ack");

        // thresh=0: wrap_count free-runs through 256 wraps back to 0.
        do_reset(8'd0);
        for (int k = 0; k < 256; k++) begin
            descend(8'(k), 1'b0, 1'b0, 1'b0, "free_desc");
            step(3'd7, 1'b0, 1'b0, 1'b1, 8'(k + 1), 1'b0, 1'b0, 1'b0, "free_wrap");
        end

        // thresh=1: completion coinciding with ack keeps period_done.
        do_reset(8'd1);
        descend(8'd0, 1'b0, 1'b0, 1'b0, "t1_d1");
        step(3'd7, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, "t1_w1_done");
        descend(8'd0, 1'b1, 1'b0, 1'b0, "t1_d2");
        step(3'd7, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, "t1_done_with_ack");
        step(3'd6, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, "t1_after");
        step(3'd5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, "t1_midcount");

        // Asynchronous reset mid-count, sampled before the next rising edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push_exp(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "async_reset");
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
